// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, decode and redirect signals of the fetch front end.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, runs one outstanding imem request at a time,
// buffers returned words and presents them to decode; accepts redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t     state;
  fetch_state_t     state_d;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_d;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_addr_d;
  logic             req_q;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  fetch_entry_t     head;
  fetch_entry_t     push_data;

  assign pop         = bus.instr_valid && bus.instr_ready;
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);
  assign push_data   = '{pc: req_addr, instr: bus.imem_rdata};

  // Next-state logic; the issue test counts the outstanding slot so pushes never overflow.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_addr_d = req_addr;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = align_pc(bus.redirect_pc);
        end else if (count < CNT_W'(QUEUE_DEPTH)) begin
          state_d    = WAIT;
          req_addr_d = fetch_pc;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          fetch_pc_d = align_pc(bus.redirect_pc);
          state_d    = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_next(req_addr);
          if (count_after < CNT_W'(QUEUE_DEPTH)) begin
            req_addr_d = pc_next(req_addr);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.redirect) fetch_pc_d = align_pc(bus.redirect_pc);
        if (bus.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_addr <= req_addr_d;
      req_q    <= (state_d != IDLE);
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect),
    .push     (push),
    .pop      (pop),
    .push_data(push_data),
    .head     (head),
    .count    (count)
  );

  assign bus.imem_req       = req_q;
  assign bus.imem_addr      = req_addr;
  // Decode-side outputs come only from queue registers and read zero when empty.
  assign bus.instr_valid    = (count != '0);
  assign bus.instr          = bus.instr_valid ? head.instr : '0;
  assign bus.instr_pc       = bus.instr_valid ? head.pc : '0;
  assign bus.instr_pc_plus4 = bus.instr_valid ? pc_next(head.pc) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// checked every cycle against a queue-based behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic clk = 1'b0;
  logic rst;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: a plain queue plus "request outstanding" and "keep result" flags.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_ins[$];
  logic [31:0] m_fetch;
  logic [31:0] m_req_addr;
  bit          m_busy;
  bit          m_keep;

  // Memory responder and consumption log.
  int          waited;
  int          cur_lat;
  int          lat_lo;
  int          lat_hi;
  logic [31:0] cons_pc[$];
  logic [31:0] cons_p4[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_ins.delete();
    m_fetch    = RESET_PC;
    m_req_addr = RESET_PC;
    m_busy     = 1'b0;
    m_keep     = 1'b0;
  endtask

  task automatic model_step();
    int unsigned n0;
    bit          pop;
    if (!rst) begin
      model_reset();
      return;
    end
    n0  = mq_pc.size();
    pop = (n0 != 0) && bus.instr_ready;
    if (bus.redirect) begin
      mq_pc.delete();
      mq_ins.delete();
      m_fetch = {bus.redirect_pc[31:2], 2'b00};
      if (m_busy) begin
        if (bus.imem_ack) m_busy = 1'b0;
        else m_keep = 1'b0;
      end
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_ins.pop_front());
      end
      if (!m_busy) begin
        if (n0 < DEPTH) begin
          m_busy     = 1'b1;
          m_keep     = 1'b1;
          m_req_addr = m_fetch;
        end
      end else if (bus.imem_ack) begin
        if (m_keep) begin
          mq_pc.push_back(m_req_addr);
          mq_ins.push_back(bus.imem_rdata);
          m_fetch = m_req_addr + 32'd4;
          if (mq_pc.size() < DEPTH) m_req_addr = m_req_addr + 32'd4;
          else m_busy = 1'b0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int unsigned n;
    n = mq_pc.size();
    check("imem_req", 32'(bus.imem_req), 32'(m_busy));
    check("imem_addr", bus.imem_addr, m_req_addr);
    check("instr_valid", 32'(bus.instr_valid), 32'(n != 0));
    check("instr", bus.instr, (n != 0) ? mq_ins[0] : 32'h0);
    check("instr_pc", bus.instr_pc, (n != 0) ? mq_pc[0] : 32'h0);
    check("instr_pc_plus4", bus.instr_pc_plus4, (n != 0) ? mq_pc[0] + 32'd4 : 32'h0);
  endtask

  task automatic drive_mem();
    if (rst && bus.imem_req && waited >= cur_lat) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem_word(bus.imem_addr);
      waited         = 0;
      cur_lat        = $urandom_range(lat_hi, lat_lo);
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      if (!rst) waited = 0;
      else if (bus.imem_req) waited++;
    end
  endtask

  // One clock: log the handshake about to happen, step model, compare, drive next inputs.
  task automatic cycle();
    if (rst && !bus.redirect && bus.instr_valid && bus.instr_ready) begin
      cons_pc.push_back(bus.instr_pc);
      cons_p4.push_back(bus.instr_pc_plus4);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    bus.redirect = 1'b0;
    drive_mem();
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_lo  = lo;
    lat_hi  = hi;
    cur_lat = lo;
  endtask

  initial begin
    logic [31:0] last;
    bit          ok;

    rst             = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;
    waited          = 0;
    set_lat(1, 1);
    model_reset();
    repeat (2) cycle();
    check("reset_req", 32'(bus.imem_req), 32'h0);
    check("reset_valid", 32'(bus.instr_valid), 32'h0);
    check("reset_addr", bus.imem_addr, RESET_PC);

    // Sequential fetch with one wait cycle per request.
    rst             = 1'b1;
    bus.instr_ready = 1'b1;
    cycle();
    check("t1_first_req", 32'(bus.imem_req), 32'h1);
    check("t1_first_addr", bus.imem_addr, RESET_PC);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cons_pc.size() >= 3) begin ok = 1'b1; break; end
      cycle();
    end
    check("t1_timeout", 32'(ok), 32'h1);
    if (ok) begin
      check("t1_pc0", cons_pc[0], 32'h0);
      check("t1_pc1", cons_pc[1], 32'h4);
      check("t1_pc2", cons_pc[2], 32'h8);
      check("t1_p40", cons_p4[0], 32'h4);
      check("t1_p41", cons_p4[1], 32'h8);
      check("t1_p42", cons_p4[2], 32'hC);
    end

    // Back-pressure: queue fills to depth, requests stop, nothing lost on release.
    bus.instr_ready = 1'b0;
    repeat (10) cycle();
    check("t2_req_low", 32'(bus.imem_req), 32'h0);
    check("t2_valid", 32'(bus.instr_valid), 32'h1);
    check("t2_model_full", 32'(mq_pc.size()), 32'(DEPTH));
    last = cons_pc[cons_pc.size() - 1];
    cons_pc.delete();
    cons_p4.delete();
    bus.instr_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cons_pc.size() >= 4) begin ok = 1'b1; break; end
      cycle();
    end
    check("t2_timeout", 32'(ok), 32'h1);
    for (int i = 0; i < cons_pc.size() && i < 4; i++)
      check("t2_order", cons_pc[i], last + 32'(4 * (i + 1)));

    // Redirect while a slow request is outstanding.
    set_lat(3, 3);
    repeat (8) cycle();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req && !bus.imem_ack) begin ok = 1'b1; break; end
      cycle();
    end
    check("t3_wait_timeout", 32'(ok), 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    cons_pc.delete();
    cons_p4.delete();
    cycle();
    check("t3_flushed", 32'(bus.instr_valid), 32'h0);
    check("t3_drop_req", 32'(bus.imem_req), 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cons_pc.size() >= 1) begin ok = 1'b1; break; end
      cycle();
    end
    check("t3_timeout", 32'(ok), 32'h1);
    if (ok) begin
      check("t3_target_pc", cons_pc[0], 32'h0000_0100);
      check("t3_target_p4", cons_p4[0], 32'h0000_0104);
    end

    // Redirect coinciding with ack and a consumer handshake.
    set_lat(0, 0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.imem_req && bus.imem_ack && bus.instr_valid) begin ok = 1'b1; break; end
      cycle();
    end
    check("t4_wait_timeout", 32'(ok), 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    cycle();
    check("t4_empty", 32'(bus.instr_valid), 32'h0);
    check("t4_req_idle", 32'(bus.imem_req), 32'h0);
    cycle();
    check("t4_req", 32'(bus.imem_req), 32'h1);
    check("t4_addr", bus.imem_addr, 32'h0000_0200);

    // Address wrap at the top of the address space.
    set_lat(0, 2);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    cons_pc.delete();
    cons_p4.delete();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (cons_pc.size() >= 2) begin ok = 1'b1; break; end
    end
    check("t5_timeout", 32'(ok), 32'h1);
    if (ok) begin
      check("t5_pc0", cons_pc[0], 32'hFFFF_FFFC);
      check("t5_p40", cons_p4[0], 32'h0);
      check("t5_pc1", cons_pc[1], 32'h0);
      check("t5_p41", cons_p4[1], 32'h4);
    end

    // Asynchronous reset in the middle of a request.
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req) begin ok = 1'b1; break; end
      cycle();
    end
    check("t6_wait_timeout", 32'(ok), 32'h1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_req_drop", 32'(bus.imem_req), 32'h0);
    check("t6_valid", 32'(bus.instr_valid), 32'h0);
    repeat (2) cycle();
    rst = 1'b1;
    cons_pc.delete();
    cons_p4.delete();
    cycle();
    check("t6_req", 32'(bus.imem_req), 32'h1);
    check("t6_addr", bus.imem_addr, RESET_PC);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cons_pc.size() >= 1) begin ok = 1'b1; break; end
      cycle();
    end
    check("t6_timeout", 32'(ok), 32'h1);
    if (ok) check("t6_refetch_pc", cons_pc[0], RESET_PC);

    // Random traffic: ready, latency and redirects all randomized.
    set_lat(0, 3);
    for (int i = 0; i < 2500; i++) begin
      bus.instr_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(31, 0) == 0) begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = ($urandom_range(3, 0) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
